// File: rtl/score_keeper_bcd.sv
// N-digit BCD score keeper: game FSM, score/high-score registers and registered
// active-low seven-segment drive for the HEX displays.
module sk_seg7 (
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    if (!i_blank) begin
      case (i_bcd)
        4'd0: o_seg = 7'b1000000;
        4'd1: o_seg = 7'b1111001;
        4'd2: o_seg = 7'b0100100;
        4'd3: o_seg = 7'b0110000;
        4'd4: o_seg = 7'b0011001;
        4'd5: o_seg = 7'b0010010;
        4'd6: o_seg = 7'b0000010;
        4'd7: o_seg = 7'b1111000;
        4'd8: o_seg = 7'b0000000;
        4'd9: o_seg = 7'b0010000;
        default: o_seg = 7'b1111111;
      endcase
    end
  end
endmodule

module score_keeper_bcd #(
  parameter int NUM_DIGITS = 3,
  parameter bit SAT_EN     = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    inc,
  input  logic                    crash,
  input  logic                    show_hi,
  input  logic                    clear_hi,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hi_bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    playing,
  output logic                    game_over,
  output logic                    new_record,
  output logic                    overflow
);
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t                       r_state, w_state_nxt;
  logic                         r_start_q, r_inc_q;
  logic [NUM_DIGITS-1:0][3:0]   r_score, r_hi, w_score_inc, w_disp;
  logic [NUM_DIGITS-1:0][6:0]   r_hex, w_seg;
  logic [NUM_DIGITS:0]          w_carry;
  logic [NUM_DIGITS-1:0]        w_blank;
  logic                         w_zrun;
  logic                         w_rise_start, w_rise_inc, w_do_inc;
  logic                         w_game_start, w_game_end;

  assign w_rise_start = start & ~r_start_q;
  assign w_rise_inc   = inc & ~r_inc_q;
  assign w_do_inc     = (r_state == S_PLAY) & w_rise_inc & ~crash;

  always_comb begin
    w_state_nxt  = r_state;
    w_game_start = 1'b0;
    w_game_end   = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: if (w_rise_start) begin
        w_state_nxt  = S_PLAY;
        w_game_start = 1'b1;
      end
      S_PLAY: if (crash) begin
        w_state_nxt = S_OVER;
        w_game_end  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ripple BCD +1; a carry out of the top digit means the score was all 9s.
  always_comb begin
    w_score_inc = r_score;
    w_carry     = '0;
    w_carry[0]  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry[i]) begin
        if (r_score[i] == 4'd9) begin
          w_score_inc[i] = 4'd0;
          w_carry[i+1]   = 1'b1;
        end else begin
          w_score_inc[i] = r_score[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_inc_q    <= 1'b0;
      r_score    <= '0;
      r_hi       <= '0;
      new_record <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      r_inc_q   <= inc;
      if (w_game_start) begin
        r_score    <= '0;
        overflow   <= 1'b0;
        new_record <= 1'b0;
      end else if (w_do_inc) begin
        if (w_carry[NUM_DIGITS]) begin
          overflow <= 1'b1;
          if (!SAT_EN) r_score <= w_score_inc;
        end else begin
          r_score <= w_score_inc;
        end
      end
      // BCD ordering matches unsigned ordering, so a plain vector compare works.
      if (w_game_end && (r_score > r_hi)) begin
        r_hi       <= r_score;
        new_record <= 1'b1;
      end
      if (clear_hi && (r_state != S_PLAY)) begin
        r_hi       <= '0;
        new_record <= 1'b0;
      end
    end
  end

  assign w_disp = show_hi ? r_hi : r_score;

  always_comb begin
    w_zrun  = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zrun     = w_zrun & (w_disp[i] == 4'd0);
      w_blank[i] = BLANK_LZ && (i != 0) && w_zrun;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    sk_seg7 u_seg (.i_bcd(w_disp[g]), .i_blank(w_blank[g]), .o_seg(w_seg[g]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        r_hex[i] <= ((i == 0) || !BLANK_LZ) ? 7'b1000000 : 7'b1111111;
    end else begin
      r_hex <= w_seg;
    end
  end

  assign score_bcd = r_score;
  assign hi_bcd    = r_hi;
  assign hex       = r_hex;
  assign playing   = (r_state == S_PLAY);
  assign game_over = (r_state == S_OVER);
endmodule

// File: tb/tb_score_keeper_bcd.sv
// Directed bench for score_keeper_bcd: 3-digit main instance plus two 2-digit
// instances (saturating and wrapping) for the overflow cases.
module tb_score_keeper_bcd;
  localparam logic [6:0] SB = 7'h7F, S0 = 7'h40, S1 = 7'h79, S2 = 7'h24,
                         S5 = 7'h12, S9 = 7'h10;

  logic clk = 1'b0;
  logic reset_n, start, inc, crash, show_hi, clear_hi;
  logic start2, inc2, crash2;
  logic [11:0] score_bcd, hi_bcd;
  logic [20:0] hex;
  logic        playing, game_over, new_record, overflow;
  logic [7:0]  s_score, s_hi, w_score, w_hi;
  logic [13:0] s_hex, w_hex;
  logic        s_pl, s_go, s_nr, s_ov, w_pl, w_go, w_nr, w_ov;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_keeper_bcd dut (
    .clk(clk), .reset_n(reset_n), .start(start), .inc(inc), .crash(crash),
    .show_hi(show_hi), .clear_hi(clear_hi), .score_bcd(score_bcd), .hi_bcd(hi_bcd),
    .hex(hex), .playing(playing), .game_over(game_over), .new_record(new_record),
    .overflow(overflow));

  score_keeper_bcd #(.NUM_DIGITS(2), .SAT_EN(1'b1), .BLANK_LZ(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start2), .inc(inc2), .crash(crash2),
    .show_hi(1'b0), .clear_hi(1'b0), .score_bcd(s_score), .hi_bcd(s_hi),
    .hex(s_hex), .playing(s_pl), .game_over(s_go), .new_record(s_nr),
    .overflow(s_ov));

  score_keeper_bcd #(.NUM_DIGITS(2), .SAT_EN(1'b0), .BLANK_LZ(1'b1)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start2), .inc(inc2), .crash(crash2),
    .show_hi(1'b0), .clear_hi(1'b0), .score_bcd(w_score), .hi_bcd(w_hi),
    .hex(w_hex), .playing(w_pl), .game_over(w_go), .new_record(w_nr),
    .overflow(w_ov));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input int hi_cycles);
    inc = 1'b1;
    repeat (hi_cycles) tick();
    inc = 1'b0;
    tick();
  endtask

  task automatic new_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic pulse_inc2();
    inc2 = 1'b1;
    tick();
    inc2 = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; start = 0; inc = 0; crash = 0; show_hi = 0; clear_hi = 0;
    start2 = 0; inc2 = 0; crash2 = 0;
    repeat (2) tick();
    chk("rst_score", score_bcd, 12'h000);
    chk("rst_hex", hex, {SB, SB, S0});
    reset_n = 1'b1;
    tick();

    // inc ignored in IDLE
    repeat (5) pulse_inc(1);
    chk("idle_score", score_bcd, 12'h000);
    chk("idle_hex", hex, {SB, SB, S0});
    chk("idle_playing", playing, 1'b0);

    new_game();
    chk("start_playing", playing, 1'b1);
    // first pulse: score on the edge, hex one edge later
    inc = 1'b1;
    tick();
    chk("inc1_score", score_bcd, 12'h001);
    chk("inc1_hex_old", hex, {SB, SB, S0});
    tick();
    chk("inc1_hex_new", hex, {SB, SB, S1});
    tick();
    inc = 1'b0;
    tick();
    repeat (11) pulse_inc(3);
    chk("play_score", score_bcd, 12'h012);
    chk("play_hex", hex, {SB, S1, S2});
    chk("play_playing", playing, 1'b1);

    crash = 1'b1;
    tick();
    crash = 1'b0;
    chk("crash_go", game_over, 1'b1);
    chk("crash_hi", hi_bcd, 12'h012);
    chk("crash_nr", new_record, 1'b1);
    repeat (2) pulse_inc(1);
    chk("over_frozen", score_bcd, 12'h012);

    // crash and inc together at 7
    new_game();
    chk("g2_clear_nr", new_record, 1'b0);
    repeat (7) pulse_inc(1);
    inc = 1'b1; crash = 1'b1;
    tick();
    inc = 1'b0; crash = 1'b0;
    chk("ci_score", score_bcd, 12'h007);
    chk("ci_go", game_over, 1'b1);
    chk("ci_hi", hi_bcd, 12'h012);
    tick();

    new_game();
    repeat (5) pulse_inc(1);
    crash = 1'b1;
    tick();
    crash = 1'b0;
    chk("g3_hi", hi_bcd, 12'h012);
    chk("g3_nr", new_record, 1'b0);
    show_hi = 1'b1;
    chk("showhi_before", hex, {SB, SB, S5});
    tick();
    chk("showhi_after", hex, {SB, S1, S2});
    show_hi = 1'b0;
    tick();

    // clear_hi in PLAY ignored, then async reset at 45
    new_game();
    repeat (45) pulse_inc(1);
    chk("g4_score", score_bcd, 12'h045);
    clear_hi = 1'b1;
    tick();
    clear_hi = 1'b0;
    chk("clr_play_hi", hi_bcd, 12'h012);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_score", score_bcd, 12'h000);
    chk("arst_hi", hi_bcd, 12'h000);
    chk("arst_hex", hex, {SB, SB, S0});
    chk("arst_playing", playing, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();

    // clear_hi in OVER
    new_game();
    repeat (3) pulse_inc(1);
    crash = 1'b1;
    tick();
    crash = 1'b0;
    chk("g5_hi", hi_bcd, 12'h003);
    clear_hi = 1'b1;
    tick();
    clear_hi = 1'b0;
    chk("clr_over_hi", hi_bcd, 12'h000);
    chk("clr_over_nr", new_record, 1'b0);

    // clear_hi with rise_start in OVER
    new_game();
    repeat (2) pulse_inc(1);
    crash = 1'b1;
    tick();
    crash = 1'b0;
    chk("g6_hi", hi_bcd, 12'h002);
    tick();
    clear_hi = 1'b1; start = 1'b1;
    tick();
    clear_hi = 1'b0; start = 1'b0;
    chk("clrst_playing", playing, 1'b1);
    chk("clrst_hi", hi_bcd, 12'h000);

    // 2-digit overflow
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    repeat (99) pulse_inc2();
    chk("sat_99", s_score, 8'h99);
    chk("wrap_99", w_score, 8'h99);
    chk("sat_hex99", s_hex, {S9, S9});
    pulse_inc2();
    chk("sat_score", s_score, 8'h99);
    chk("sat_ov", s_ov, 1'b1);
    chk("wrap_score", w_score, 8'h00);
    chk("wrap_ov", w_ov, 1'b1);
    chk("wrap_hex", w_hex, {SB, S0});
    pulse_inc2();
    chk("wrap_next", w_score, 8'h01);
    chk("wrap_ov_sticky", w_ov, 1'b1);
    crash2 = 1'b1;
    tick();
    crash2 = 1'b0;
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("restart_sat_ov", s_ov, 1'b0);
    chk("restart_wrap_ov", w_ov, 1'b0);
    chk("restart_score", s_score, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
